// File: rtl/fighter_pkg.sv
// rtl/fighter_pkg.sv - shared state type, counter width and parameter defaults for the fighter sequencer
package fighter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WALK     = 2'd1,
        ATTACK   = 2'd2,
        COOLDOWN = 2'd3
    } fstate_t;

    localparam int FRAME_CNT_W    = 4;

    localparam int X_W_DEF        = 10;
    localparam int X_MIN_DEF      = 0;
    localparam int X_MAX_DEF      = 560;
    localparam int X_STEP_DEF     = 2;
    localparam int MIN_GAP_DEF    = 64;
    localparam int P1_X_INIT_DEF  = 80;
    localparam int P2_X_INIT_DEF  = 480;
    localparam int ATK_FRAMES_DEF = 12;
    localparam int CD_FRAMES_DEF  = 8;

endpackage

// File: rtl/fighter_fsm.sv
// rtl/fighter_fsm.sv - per-player action FSM producing state, facing, hit pulse and saturated candidate x
// Optional FIGHTER_ATK_HOLD_EN: attack key is level-sensitive (auto-repeat while held).
module fighter_fsm
    import fighter_pkg::*;
#(
    parameter int   X_W        = X_W_DEF,
    parameter int   X_MIN      = X_MIN_DEF,
    parameter int   X_MAX      = X_MAX_DEF,
    parameter int   X_STEP     = X_STEP_DEF,
    parameter int   ATK_FRAMES = ATK_FRAMES_DEF,
    parameter int   CD_FRAMES  = CD_FRAMES_DEF,
    parameter logic FACE_INIT  = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_tick,
    input  logic                i_move_l,
    input  logic                i_move_r,
    input  logic                i_attack,
    input  logic [X_W-1:0]      i_x,
    output fstate_t             o_state,
    output logic                o_face,
    output logic                o_hit,
    output logic signed [X_W:0] o_cand
);

    localparam logic signed [X_W:0] L_STEP = (X_W+1)'(X_STEP);
    localparam logic signed [X_W:0] L_MIN  = (X_W+1)'(X_MIN);
    localparam logic signed [X_W:0] L_MAX  = (X_W+1)'(X_MAX);

    fstate_t                r_state, w_state_nxt;
    logic [FRAME_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic                   r_face, w_face_nxt;
    logic                   r_hit, w_hit_nxt;
    logic                   w_atk_req;
    logic signed [X_W:0]    w_step;
    logic signed [X_W:0]    w_raw;

`ifdef FIGHTER_ATK_HOLD_EN
    assign w_atk_req = i_attack;
`else
    logic r_atk_prev;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_atk_prev <= 1'b0;
        else if (i_tick)
            r_atk_prev <= i_attack;
    end

    assign w_atk_req = i_attack & ~r_atk_prev;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_face  <= FACE_INIT;
            r_hit   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_face  <= w_face_nxt;
            r_hit   <= w_hit_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_face_nxt  = r_face;
        w_hit_nxt   = 1'b0;
        w_step      = '0;
        if (i_tick) begin
            case (r_state)
                IDLE, WALK: begin
                    if (w_atk_req) begin
                        w_state_nxt = ATTACK;
                        w_cnt_nxt   = '0;
                    end else if (i_move_l ^ i_move_r) begin
                        w_state_nxt = WALK;
                        w_face_nxt  = i_move_r;
                        w_step      = i_move_r ? L_STEP : -L_STEP;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                ATTACK: begin
                    w_hit_nxt = (r_cnt == FRAME_CNT_W'(ATK_FRAMES / 2));
                    if (r_cnt == FRAME_CNT_W'(ATK_FRAMES - 1)) begin
                        w_state_nxt = COOLDOWN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (r_cnt == FRAME_CNT_W'(CD_FRAMES - 1)) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // One extra sign bit keeps a step left of X_MIN from wrapping before the clamp.
    assign w_raw = $signed({1'b0, i_x}) + w_step;

    always_comb begin
        if (w_raw < L_MIN)
            o_cand = L_MIN;
        else if (w_raw > L_MAX)
            o_cand = L_MAX;
        else
            o_cand = w_raw;
    end

    assign o_state = r_state;
    assign o_face  = r_face;
    assign o_hit   = r_hit;

endmodule

// File: rtl/fighter_action_ctrl.sv
// rtl/fighter_action_ctrl.sv - frame-tick action sequencer for two fighters with no-overlap position arbitration
// Optional FIGHTER_ATK_HOLD_EN: held attack key auto-repeats after cooldown.
module fighter_action_ctrl
    import fighter_pkg::*;
#(
    parameter int X_W        = X_W_DEF,
    parameter int X_MIN      = X_MIN_DEF,
    parameter int X_MAX      = X_MAX_DEF,
    parameter int X_STEP     = X_STEP_DEF,
    parameter int MIN_GAP    = MIN_GAP_DEF,
    parameter int P1_X_INIT  = P1_X_INIT_DEF,
    parameter int P2_X_INIT  = P2_X_INIT_DEF,
    parameter int ATK_FRAMES = ATK_FRAMES_DEF,
    parameter int CD_FRAMES  = CD_FRAMES_DEF
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           frame_clk,
    input  logic           p1_move_l,
    input  logic           p1_move_r,
    input  logic           p1_attack,
    input  logic           p2_move_l,
    input  logic           p2_move_r,
    input  logic           p2_attack,
    output logic [X_W-1:0] p1_x,
    output logic [X_W-1:0] p2_x,
    output fstate_t        p1_state,
    output fstate_t        p2_state,
    output logic           p1_face,
    output logic           p2_face,
    output logic           p1_hit,
    output logic           p2_hit
);

    localparam logic signed [X_W:0] L_GAP = (X_W+1)'(MIN_GAP);

    logic                r_frame_q;
    logic                w_tick;
    logic [X_W-1:0]      r_p1_x, r_p2_x;
    logic [X_W-1:0]      w_p1_x_nxt, w_p2_x_nxt;
    logic signed [X_W:0] w_cand1, w_cand2, w_gap;
    logic                w_p1_in, w_p2_in;

    assign w_tick = frame_clk & ~r_frame_q;

    fighter_fsm #(
        .X_W(X_W), .X_MIN(X_MIN), .X_MAX(X_MAX), .X_STEP(X_STEP),
        .ATK_FRAMES(ATK_FRAMES), .CD_FRAMES(CD_FRAMES), .FACE_INIT(1'b1)
    ) u_p1 (
        .i_clk(Clk), .i_reset(Reset), .i_tick(w_tick),
        .i_move_l(p1_move_l), .i_move_r(p1_move_r), .i_attack(p1_attack),
        .i_x(r_p1_x), .o_state(p1_state), .o_face(p1_face), .o_hit(p1_hit), .o_cand(w_cand1)
    );

    fighter_fsm #(
        .X_W(X_W), .X_MIN(X_MIN), .X_MAX(X_MAX), .X_STEP(X_STEP),
        .ATK_FRAMES(ATK_FRAMES), .CD_FRAMES(CD_FRAMES), .FACE_INIT(1'b0)
    ) u_p2 (
        .i_clk(Clk), .i_reset(Reset), .i_tick(w_tick),
        .i_move_l(p2_move_l), .i_move_r(p2_move_r), .i_attack(p2_attack),
        .i_x(r_p2_x), .o_state(p2_state), .o_face(p2_face), .o_hit(p2_hit), .o_cand(w_cand2)
    );

    // Candidates equal the current x outside tick cycles, so committing every cycle is harmless.
    always_comb begin
        w_gap   = w_cand2 - w_cand1;
        w_p1_in = w_cand1 > $signed({1'b0, r_p1_x});
        w_p2_in = w_cand2 < $signed({1'b0, r_p2_x});
        w_p1_x_nxt = w_cand1[X_W-1:0];
        w_p2_x_nxt = w_cand2[X_W-1:0];
        if (w_gap < L_GAP) begin
            if (w_p1_in)
                w_p1_x_nxt = r_p1_x;
            if (w_p2_in)
                w_p2_x_nxt = r_p2_x;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_frame_q <= 1'b0;
            r_p1_x    <= X_W'(P1_X_INIT);
            r_p2_x    <= X_W'(P2_X_INIT);
        end else begin
            r_frame_q <= frame_clk;
            r_p1_x    <= w_p1_x_nxt;
            r_p2_x    <= w_p2_x_nxt;
        end
    end

    assign p1_x = r_p1_x;
    assign p2_x = r_p2_x;

endmodule
